multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Successor to the single-cycle combinational decoder: a Moore FSM control unit for a multicycle RV32I datapath with a shared instruction/data memory.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Adds a parametrised memory wait-state counter, JAL support, and sticky illegal-instruction detection.
- Sits between the instruction register (Op/Funct fields) and the datapath muxes, ULA, register file and memory.

Parameters:
- MEM_WAIT, 0: extra wait cycles per memory access (0..15). Applies in FETCH, MEMREAD and MEMWRITE.
- ENABLE_JAL, 1: 1 = JAL (1101111) supported; 0 = JAL is illegal.
- ULA_CTRL_W, 3: ULAControl width (≥3). Upper bits are driven 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Op  in  7  instruction opcode from the IR
- Funct3  in  3  instruction funct3
- Funct7  in  7  instruction funct7
- Zero  in  1  ULA zero flag
- PCWrite  out  1  PC register enable (includes branch decision)
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ULA result
- ULASrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- ULASrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ULAControl  out  ULA_CTRL_W  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- RegWrite  out  1  register file write enable
- Illegal  out  1  sticky illegal-instruction flag
- State  out  4  current state code, for debug

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: State = FETCH(0) and wait counter = 0.
  - While reset is high, PCWrite = IRWrite = RegWrite = MemWrite = Illegal = 0.
  - All other outputs take their FETCH values.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 15.
- Outputs are Moore; ImmSrc is the only exception. Any output not listed for a state is 0.
- Wait counter:
  - In memory states, the counter increments each cycle until it reaches MEM_WAIT.
  - That cycle is the "last cycle"; the state advances and the counter clears.
  - With MEM_WAIT = 0, every memory state lasts exactly 1 cycle.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, ULASrcA=00, ULASrcB=10, add, ResultSrc=10. IRWrite=1 and PCWrite=1 on the last cycle only. Then → DECODE.
  - DECODE: ULASrcA=01, ULASrcB=01, add (computes the branch/jump target).
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → ILLEGAL
  - MEMADR: ULASrcA=10, ULASrcB=01, add. Load → MEMREAD; store → MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Last cycle → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 on the last cycle only, then → FETCH.
  - EXECUTER: ULASrcA=10, ULASrcB=00, ULAControl decoded → ALUWB.
    - Funct7=0000000: Funct3 000 add, 111 and, 110 or, 010 slt, 100 xor.
    - Funct7=0100000 with Funct3=000: sub.
  - EXECUTEI: ULASrcA=10, ULASrcB=01, same Funct3 map as EXECUTER (Funct7 ignored) → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - BEQ: ULASrcA=10, ULASrcB=00, sub, ResultSrc=00, PCWrite=Zero → FETCH.
  - JAL: ULASrcA=01, ULASrcB=10, add, ResultSrc=00, PCWrite=1 → ALUWB (writes PC+4 to rd).
  - ILLEGAL: Illegal=1, all enables 0. Stays in ILLEGAL until reset.
- Illegal decode (checked in DECODE):
  - Opcode not in the list above.
  - JAL with ENABLE_JAL=0.
  - R-type Funct7 not in {0000000, 0100000}.
  - 0100000 with Funct3 ≠ 000.
  - R-type or I-type Funct3 not in {000, 111, 110, 010, 100}.
  - BEQ with Funct3 ≠ 000.
  - Load/store Funct3 is ignored (byte/word width is handled by memory).
- ImmSrc is combinational from Op in every state: 0100011 → 01, 1100011 → 10, 1101111 → 11, otherwise 00.
- Latency in cycles, with W = MEM_WAIT:
  - lw: 5+2W
  - sw: 4+2W
  - R-type / I-type: 4+W
  - beq: 3+W
  - jal: 4+W
- Reset mid-instruction: returns to FETCH immediately and the counter clears. No write enable glitches high while reset is asserted.
- Op/Funct must stay stable from DECODE until the instruction returns to FETCH; the IR is only written in FETCH.

Test Plan:
1. Reset held, then released; MEM_WAIT=0; Op=0110011, F7=0100000, F3=000 → States 0,1,6,8,0. ULAControl=001 in state 6. RegWrite=1 only in state 8. No enables high during reset.
2. lw (Op=0000011), MEM_WAIT=2 → FETCH lasts 3 cycles with IRWrite/PCWrite only in the 3rd. MEMREAD lasts 3 cycles. MEMWB has RegWrite=1 and ResultSrc=01. Total 9 cycles.
3. sw (Op=0100011), MEM_WAIT=0 → ImmSrc=01. MemWrite=1 for exactly 1 cycle in state 5 with AdrSrc=1. RegWrite is never 1.
4. beq with Zero=1, then beq with Zero=0 → state 9 gives PCWrite=1 in the first case and 0 in the second. ULAControl=001 and ImmSrc=10 in both.
5. jal with ENABLE_JAL=1 → states 0,1,10,8. PCWrite=1 in state 10. ImmSrc=11. With ENABLE_JAL=0 the same Op → state 15, Illegal=1 held for 10 cycles, cleared only by reset.
6. addi/xori/slti (Op=0010011, F3=000/100/010) → ULAControl 000/100/101 in state 7. F3=001 → ILLEGAL. Asserting reset in MEMREAD → State=0 asynchronously.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the RV32I datapath.
// The control unit is the master; the datapath/IR side is the slave.
interface multicycle_control_unit_if #(
    parameter int ULA_CTRL_W = 3
);
    logic [6:0]            Op;
    logic [2:0]            Funct3;
    logic [6:0]            Funct7;
    logic                  Zero;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ULASrcA;
    logic [1:0]            ULASrcB;
    logic [1:0]            ImmSrc;
    logic [ULA_CTRL_W-1:0] ULAControl;
    logic                  RegWrite;
    logic                  Illegal;
    logic [3:0]            State;

    modport master (
        input  Op, Funct3, Funct7, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ULASrcA, ULASrcB,
               ImmSrc, ULAControl, RegWrite, Illegal, State
    );

    modport slave (
        output Op, Funct3, Funct7, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ULASrcA, ULASrcB,
               ImmSrc, ULAControl, RegWrite, Illegal, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle RV32I datapath with shared memory,
// memory wait states, optional JAL and a sticky illegal-instruction state.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC on last wait cycle
// DECODE   | compute OldPC+imm (branch/jump target), dispatch on opcode
// MEMADR   | rs1+imm address for load/store
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write ReadData to rd
// MEMWRITE | write rs2 to memory at ALUOut
// EXECUTER | R-type ALU operation
// EXECUTEI | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, take target when Zero
// JAL      | ALUOut <= OldPC+4, PC <= target
// ILLEGAL  | sticky trap, left only by reset
module multicycle_control_unit #(
    parameter int MEM_WAIT   = 0,
    parameter bit ENABLE_JAL = 1'b1,
    parameter int ULA_CTRL_W = 3
) (
    input  logic clk,
    input  logic reset,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t                state, state_nxt, decode_tgt;
    logic [3:0]            wait_cnt, wait_nxt;
    logic                  mem_state, last;
    logic                  f3_ok;
    logic [2:0]            alu_fn;
    logic [ULA_CTRL_W-1:0] ula_ctl;
    logic                  pcw, irw, mw, rw;

    always_comb begin
        f3_ok = bus.Funct3 inside {3'b000, 3'b111, 3'b110, 3'b010, 3'b100};
        decode_tgt = S_ILLEGAL;
        case (bus.Op)
            OP_LOAD, OP_STORE: decode_tgt = S_MEMADR;
            OP_R: begin
                if ((bus.Funct7 == 7'b0 && f3_ok) ||
                    (bus.Funct7 == F7_ALT && bus.Funct3 == 3'b000))
                    decode_tgt = S_EXECUTER;
            end
            OP_I:   if (f3_ok) decode_tgt = S_EXECUTEI;
            OP_BEQ: if (bus.Funct3 == 3'b000) decode_tgt = S_BEQ;
            OP_JAL: if (ENABLE_JAL) decode_tgt = S_JAL;
            default: decode_tgt = S_ILLEGAL;
        endcase
    end

    // Funct7 only selects sub for R-type; I-type ignores it
    always_comb begin
        case (bus.Funct3)
            3'b000:  alu_fn = (state == S_EXECUTER && bus.Funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_fn = ALU_AND;
            3'b110:  alu_fn = ALU_OR;
            3'b010:  alu_fn = ALU_SLT;
            3'b100:  alu_fn = ALU_XOR;
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
        last      = (wait_cnt == WAIT_MAX);
        wait_nxt  = (mem_state && !last) ? wait_cnt + 4'd1 : 4'd0;
        state_nxt = state;
        case (state)
            S_FETCH:    if (last) state_nxt = S_DECODE;
            S_DECODE:   state_nxt = decode_tgt;
            S_MEMADR:   state_nxt = (bus.Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (last) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (last) state_nxt = S_FETCH;
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BEQ:      state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_ILLEGAL:  state_nxt = S_ILLEGAL;
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Outputs decode the registered state so FETCH is correct right after reset release
    always_comb begin
        pcw           = 1'b0;
        irw           = 1'b0;
        mw            = 1'b0;
        rw            = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ULASrcA   = 2'b00;
        bus.ULASrcB   = 2'b00;
        ula_ctl       = '0;
        case (state)
            S_FETCH: begin
                bus.ULASrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                irw           = last;
                pcw           = last;
            end
            S_DECODE: begin
                bus.ULASrcA = 2'b01;
                bus.ULASrcB = 2'b01;
            end
            S_MEMADR: begin
                bus.ULASrcA = 2'b10;
                bus.ULASrcB = 2'b01;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                rw            = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mw         = last;
            end
            S_EXECUTER: begin
                bus.ULASrcA  = 2'b10;
                ula_ctl[2:0] = alu_fn;
            end
            S_EXECUTEI: begin
                bus.ULASrcA  = 2'b10;
                bus.ULASrcB  = 2'b01;
                ula_ctl[2:0] = alu_fn;
            end
            S_ALUWB:    rw = 1'b1;
            S_BEQ: begin
                bus.ULASrcA  = 2'b10;
                ula_ctl[2:0] = ALU_SUB;
                pcw          = bus.Zero;
            end
            S_JAL: begin
                bus.ULASrcA = 2'b01;
                bus.ULASrcB = 2'b10;
                pcw         = 1'b1;
            end
            default: ;
        endcase
        bus.ULAControl = ula_ctl;
        bus.PCWrite    = pcw && !reset;
        bus.IRWrite    = irw && !reset;
        bus.MemWrite   = mw && !reset;
        bus.RegWrite   = rw && !reset;
        bus.Illegal    = (state == S_ILLEGAL) && !reset;
        bus.State      = state;
    end

    always_comb begin
        case (bus.Op)
            OP_STORE: bus.ImmSrc = 2'b01;
            OP_BEQ:   bus.ImmSrc = 2'b10;
            OP_JAL:   bus.ImmSrc = 2'b11;
            default:  bus.ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: two control units (MEM_WAIT=0/JAL on, MEM_WAIT=2/JAL off)
// run the same instruction stream; per-cycle expected outputs are queued and compared.
module tb_multicycle_control_unit;
    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       rw;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if ifa ();
    multicycle_control_unit_if ifb ();

    multicycle_control_unit #(.MEM_WAIT(0), .ENABLE_JAL(1'b1), .ULA_CTRL_W(3)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    multicycle_control_unit #(.MEM_WAIT(2), .ENABLE_JAL(1'b0), .ULA_CTRL_W(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    exp_t obs_a, obs_b;
    always_comb obs_a = {ifa.State, ifa.PCWrite, ifa.AdrSrc, ifa.MemWrite, ifa.IRWrite,
                         ifa.ResultSrc, ifa.ULASrcA, ifa.ULASrcB, ifa.ImmSrc, ifa.ULAControl,
                         ifa.RegWrite, ifa.Illegal};
    always_comb obs_b = {ifb.State, ifb.PCWrite, ifb.AdrSrc, ifb.MemWrite, ifb.IRWrite,
                         ifb.ResultSrc, ifb.ULASrcA, ifb.ULASrcB, ifb.ImmSrc, ifb.ULAControl,
                         ifb.RegWrite, ifb.Illegal};

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [6:0] cur_op, cur_f7;
    logic [2:0] cur_f3;
    logic       cur_z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] alu_of(input bit rtype);
        case (cur_f3)
            3'b000:  return (rtype && cur_f7 == 7'b0100000) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t expect_of(input logic [3:0] st, input bit last);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.imm = (cur_op == 7'b0100011) ? 2'b01 :
                (cur_op == 7'b1100011) ? 2'b10 :
                (cur_op == 7'b1101111) ? 2'b11 : 2'b00;
        case (st)
            4'd0:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = last; e.pcw = last; end
            4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd3:  e.adr = 1'b1;
            4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
            4'd5:  begin e.adr = 1'b1; e.mw = last; end
            4'd6:  begin e.sa = 2'b10; e.alu = alu_of(1'b1); end
            4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_of(1'b0); end
            4'd8:  e.rw = 1'b1;
            4'd9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = cur_z; end
            4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            4'd15: e.ill = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic push(input bit b, input exp_t e);
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
    endtask

    // Expected cycle-by-cycle trace of one instruction for unit b (0: W=0/JAL, 1: W=2/no JAL)
    task automatic push_instr(input bit b);
        int         w;
        bit         ill;
        logic [3:0] path[$];
        w   = b ? 2 : 0;
        ill = 1'b0;
        for (int i = 0; i <= w; i++) push(b, expect_of(4'd0, i == w));
        push(b, expect_of(4'd1, 1'b0));
        case (cur_op)
            7'b0000011: path = '{4'd2, 4'd3, 4'd4};
            7'b0100011: path = '{4'd2, 4'd5};
            7'b0110011: begin
                if ((cur_f7 == 7'b0 && cur_f3 inside {3'b000, 3'b111, 3'b110, 3'b010, 3'b100}) ||
                    (cur_f7 == 7'b0100000 && cur_f3 == 3'b000)) path = '{4'd6, 4'd8};
                else ill = 1'b1;
            end
            7'b0010011: begin
                if (cur_f3 inside {3'b000, 3'b111, 3'b110, 3'b010, 3'b100}) path = '{4'd7, 4'd8};
                else ill = 1'b1;
            end
            7'b1100011: if (cur_f3 == 3'b000) path = '{4'd9}; else ill = 1'b1;
            7'b1101111: if (!b) path = '{4'd10, 4'd8}; else ill = 1'b1;
            default:    ill = 1'b1;
        endcase
        foreach (path[k]) begin
            if (path[k] == 4'd3 || path[k] == 4'd5)
                for (int i = 0; i <= w; i++) push(b, expect_of(path[k], i == w));
            else
                push(b, expect_of(path[k], 1'b0));
        end
        if (ill) for (int i = 0; i < 10; i++) push(b, expect_of(4'd15, 1'b0));
        else     push(b, expect_of(4'd0, w == 0));
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z);
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
        ifa.Op = op; ifa.Funct3 = f3; ifa.Funct7 = f7; ifa.Zero = z;
        ifb.Op = op; ifb.Funct3 = f3; ifb.Funct7 = f7; ifb.Zero = z;
    endtask

    task automatic cmp(input string name, input bit b, input exp_t e);
        exp_t o;
        o = b ? obs_b : obs_a;
        check($sformatf("%s.%s.state", name, b ? "b" : "a"), 32'(o.st), 32'(e.st));
        check($sformatf("%s.%s.ctrl", name, b ? "b" : "a"), 32'(o[16:0]), 32'(e[16:0]));
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z);
        @(negedge clk);
        reset = 1'b1;
        drive(op, f3, f7, z);
        #1;
        cmp({name, ".rst"}, 1'b0, expect_of(4'd0, 1'b0));
        cmp({name, ".rst"}, 1'b1, expect_of(4'd0, 1'b0));
        @(posedge clk);
        #2 reset = 1'b0;
        push_instr(1'b0);
        push_instr(1'b1);
        while (q_a.size() > 0 || q_b.size() > 0) begin
            @(negedge clk);
            if (q_a.size() > 0) cmp(name, 1'b0, q_a.pop_front());
            if (q_b.size() > 0) cmp(name, 1'b1, q_b.pop_front());
        end
    endtask

    initial begin
        drive(7'b0110011, 3'b000, 7'b0100000, 1'b0);
        repeat (2) @(posedge clk);
        run_instr("sub",   7'b0110011, 3'b000, 7'b0100000, 1'b0);
        run_instr("and",   7'b0110011, 3'b111, 7'b0000000, 1'b0);
        run_instr("lw",    7'b0000011, 3'b010, 7'b0000000, 1'b0);
        run_instr("sw",    7'b0100011, 3'b010, 7'b0000000, 1'b0);
        run_instr("beq1",  7'b1100011, 3'b000, 7'b0000000, 1'b1);
        run_instr("beq0",  7'b1100011, 3'b000, 7'b0000000, 1'b0);
        run_instr("jal",   7'b1101111, 3'b000, 7'b0000000, 1'b0);
        run_instr("addi",  7'b0010011, 3'b000, 7'b0100000, 1'b0);
        run_instr("xori",  7'b0010011, 3'b100, 7'b0000000, 1'b0);
        run_instr("slti",  7'b0010011, 3'b010, 7'b0000000, 1'b0);
        run_instr("ilf3",  7'b0010011, 3'b001, 7'b0000000, 1'b0);
        run_instr("ilsub", 7'b0110011, 3'b111, 7'b0100000, 1'b0);
        run_instr("ilf7",  7'b0110011, 3'b000, 7'b0000001, 1'b0);
        run_instr("ilbeq", 7'b1100011, 3'b001, 7'b0000000, 1'b0);
        run_instr("ilop",  7'b0000000, 3'b000, 7'b0000000, 1'b0);

        // Asynchronous reset while unit b sits in MEMREAD
        @(negedge clk);
        reset = 1'b1;
        drive(7'b0000011, 3'b010, 7'b0000000, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 20 && ifb.State != 4'd3; i++) @(negedge clk);
        check("memread.reached", 32'(ifb.State), 32'd3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async.b.state", 32'(ifb.State), 32'd0);
        check("async.b.en", 32'({ifb.PCWrite, ifb.IRWrite, ifb.RegWrite, ifb.MemWrite, ifb.Illegal}), 32'd0);
        check("async.a.state", 32'(ifa.State), 32'd0);
        check("async.a.en", 32'({ifa.PCWrite, ifa.IRWrite, ifa.RegWrite, ifa.MemWrite, ifa.Illegal}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("after.b.fetch", 32'(ifb.State), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
